// File: rtl/mm_cpu_core_if.sv
// mm_cpu_core_if: instruction and data memory bus of mm_cpu_core.
interface mm_cpu_core_if #(parameter int DATA_W = 32, ADDR_W = 10, OP_W = 4);
  localparam int INSTR_W = OP_W + 3 * ADDR_W;
  logic [ADDR_W-1:0] imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_rdata;
  logic [DATA_W-1:0] dmem_wdata;
  logic dmem_we;
  modport master(output imem_addr, dmem_addr, dmem_wdata, dmem_we, input imem_rdata, dmem_rdata);
  modport slave(input imem_addr, dmem_addr, dmem_wdata, dmem_we, output imem_rdata, dmem_rdata);
endinterface

// File: rtl/mm_cpu_core.sv
// mm_cpu_core: multi-cycle memory-to-memory CPU, instr = {op, A, B, C}, mem[C] = mem[A] op mem[B].
// Define MM_CPU_INSTRET_EN to build the retired-instruction counter.
module mm_cpu_core #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int OP_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  mm_cpu_core_if.master bus,
  output logic halted,
  output logic [31:0] instret
);
  localparam int INSTR_W = OP_W + 3 * ADDR_W;
  typedef enum logic [2:0] {FETCH, DEC, RDA, WB, HALT} state_t;
  state_t state, nxt;
  logic [ADDR_W-1:0] pc, pc_inc, pc_nxt, a, b, c;
  logic [INSTR_W-1:0] ir, cur;
  logic [DATA_W-1:0] opa, rd, alu;
  logic [OP_W-1:0] op;
  logic is_jump, is_halt, is_beqz, is_alu, is_nop, zero;
  // In DEC the word arrives on the bus; later states work from the latched copy
  assign cur = state == DEC ? bus.imem_rdata : ir;
  assign op = cur[INSTR_W-1 -: OP_W];
  assign a = cur[3*ADDR_W-1 -: ADDR_W];
  assign b = cur[2*ADDR_W-1 -: ADDR_W];
  assign c = cur[ADDR_W-1:0];
  assign rd = bus.dmem_rdata;
  assign is_jump = op == OP_W'(3);
  assign is_beqz = op == OP_W'(6);
  assign is_halt = op == OP_W'(7);
  assign is_alu = op < OP_W'(3) || op == OP_W'(4) || op == OP_W'(5);
  assign is_nop = !(is_alu || is_jump || is_beqz || is_halt);
  assign zero = rd == '0;
  assign pc_inc = pc + ADDR_W'(1);
  assign alu = op == OP_W'(0) ? opa & rd :
               op == OP_W'(1) ? opa | rd :
               op == OP_W'(2) ? opa ^ rd :
               op == OP_W'(4) ? opa + rd : opa - rd;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= FETCH;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      FETCH: nxt = run ? DEC : FETCH;
      DEC:   nxt = is_halt ? HALT : (is_jump || is_nop) ? FETCH : RDA;
      RDA:   nxt = is_beqz ? FETCH : WB;
      WB:    nxt = FETCH;
      default: nxt = HALT;
    endcase
  end
  assign pc_nxt = state == DEC && is_jump ? a :
                  state == RDA && is_beqz && zero ? b :
                  (state == DEC && is_nop) || (state == RDA && is_beqz) || state == WB ? pc_inc : pc;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pc <= '0;
      ir <= '0;
      opa <= '0;
    end else begin
      pc <= pc_nxt;
      ir <= state == DEC ? bus.imem_rdata : ir;
      opa <= state == RDA ? rd : opa;
    end
  assign bus.imem_addr = pc;
  assign bus.dmem_we = state == WB;
  assign bus.dmem_addr = state == DEC ? a : state == RDA ? b : state == WB ? c : '0;
  assign bus.dmem_wdata = state == WB ? alu : '0;
  assign halted = state == HALT;
`ifdef MM_CPU_INSTRET_EN
  logic retire;
  assign retire = (state == DEC || state == RDA || state == WB) && (nxt == FETCH || nxt == HALT);
  always_ff @(posedge clk or negedge rst)
    if (!rst) instret <= '0;
    else instret <= retire ? instret + 32'd1 : instret;
`else
  assign instret = '0;
`endif
endmodule

// File: doc/mm_cpu_core.md
MM_CPU_CORE -- requirements
Module: mm_cpu_core

Interface
REQ-001 SHALL have parameter DATA_W, default 32: data word width.
REQ-002 SHALL have parameter ADDR_W, default 10: instruction and data address width.
REQ-003 SHALL have parameter OP_W, default 4: opcode width; INSTR_W = OP_W + 3*ADDR_W, instr = {op, A, B, C}.
REQ-004 SHALL have port clk  in  1: single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  in  1: asynchronous, active-low reset.
REQ-006 SHALL have port run  in  1: fetch enable; when 0 the core holds in FETCH.
REQ-007 SHALL have port imem_addr  out  ADDR_W: instruction address, equals pc.
REQ-008 SHALL have port imem_rdata  in  INSTR_W: instruction word, valid one cycle after imem_addr.
REQ-009 SHALL have port dmem_addr  out  ADDR_W: data address.
REQ-010 SHALL have port dmem_rdata  in  DATA_W: read data, valid one cycle after dmem_addr.
REQ-011 SHALL have port dmem_wdata  out  DATA_W: write data.
REQ-012 SHALL have port dmem_we  out  1: write strobe; the write occurs at the clock edge ending the cycle.
REQ-013 SHALL have port halted  out  1: high once HALT has executed.
REQ-014 SHALL have port instret  out  32: retired-instruction count (see Configuration).

Function
REQ-015 SHALL decode opcodes as 0 AND, 1 OR, 2 XOR, 3 JUMP, 4 ADD, 5 SUB, 6 BEQZ, 7 HALT; all other codes execute as NOP.
REQ-016 SHALL implement states FETCH, DEC, RDA, WB, HALT.
REQ-017 FETCH: imem_addr=pc; go to DEC if run=1, else remain in FETCH.
REQ-018 DEC: latch ir<=imem_rdata; dmem_addr=imem_rdata.A.
REQ-019 DEC exits: JUMP sets pc<=A and goes to FETCH; HALT goes to HALT; NOP sets pc<=pc+1 and goes to FETCH; all others go to RDA.
REQ-020 RDA: opa<=dmem_rdata; dmem_addr=ir.B.
REQ-021 RDA exits: BEQZ sets pc<=(dmem_rdata==0 ? ir.B : pc+1) and goes to FETCH; ALU ops go to WB.
REQ-022 WB: dmem_we=1, dmem_addr=ir.C, dmem_wdata=opa OP dmem_rdata; pc<=pc+1; go to FETCH.
REQ-023 Latency SHALL be: ALU op 4 cycles, BEQZ 3, JUMP/NOP 2, FETCH to HALT 2.
REQ-024 ADD/SUB SHALL wrap modulo 2^DATA_W; no flags are kept.
REQ-025 pc+1 SHALL wrap from 2^ADDR_W-1 to 0.
REQ-026 dmem_we SHALL be 1 only in WB; dmem_addr and dmem_wdata SHALL be 0 in FETCH and HALT.
REQ-027 HALT state SHALL hold pc and set halted=1 until reset; run is ignored in HALT.
REQ-028 A write to address C equal to A or B SHALL use the operands read earlier in the same instruction.
REQ-029 Deasserting run SHALL take effect only in FETCH; an in-flight instruction completes.

Reset
REQ-030 On rst=0, regardless of clock, the core SHALL set state=FETCH, pc=0, ir=0, opa=0, halted=0, instret=0.
REQ-031 During reset, outputs SHALL be imem_addr=0, dmem_addr=0, dmem_wdata=0, dmem_we=0.
REQ-032 Reset asserted during WB SHALL drop dmem_we immediately with no write committed.
REQ-033 After rst returns to 1, the first fetch SHALL be at address 0 on the next edge with run=1.

Configuration
REQ-034 With MM_CPU_INSTRET_EN defined, instret SHALL increment by 1 on every instruction completion (JUMP, NOP, BEQZ, ALU, HALT), wrapping at 2^32.
REQ-035 Without MM_CPU_INSTRET_EN, instret SHALL be tied to 0 and the counter SHALL not be built.

Verification
REQ-036 mem8=0x00890005, mem9=0x00880006, instr0={OR,8,9,10}, run=1 -> mem10=0x00890007 written in the 4th cycle after reset release.
REQ-037 instr1={JUMP,4,0,0}, instr4={AND,10,11,12}, mem11=0x00F90005 -> imem_addr sequence 0,1,4, addresses 2-3 never fetched, mem12=0x00890005.
REQ-038 mem13=0xFFFFFFFF, mem14=1, {ADD,13,14,15} -> mem15=0; {SUB,14,13,16} -> mem16=2.
REQ-039 {BEQZ,20,7,0} at pc=5: mem20=0 -> next pc=7; mem20=3 -> next pc=6; no dmem_we in either case.
REQ-040 rst=0 pulsed mid-WB -> dmem_we falls the same time step, target word unchanged, pc=0, fetch restarts at 0.
REQ-041 With MM_CPU_INSTRET_EN: OR, JUMP, AND, HALT program -> instret=4, halted=1, pc frozen; without the macro -> instret=0.
